// File: rtl/fetch_prefetch_buffer.sv
// Fetch front end: loadable big-endian instruction memory with a synchronous read,
// a self-sequenced fetch PC and a prefetch FIFO that hands {pc, instr} to decode.
module fetch_prefetch_buffer #(
  parameter int unsigned MEM_BYTES  = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        misalign_err
);

  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  // Memory is kept as big-endian words; fetch and load are always word-aligned.
  logic [31:0]      mem_q [MEM_WORDS];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      rd_instr_q, rd_instr_d;
  logic [31:0]      rd_pc_q, rd_pc_d;
  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [31:0]      fifo_instr_d [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             unused_load_bits;

  assign fetch_idx        = fetch_pc_q[IDX_W+1:2];
  assign load_idx         = load_addr[IDX_W+1:2];
  assign unused_load_bits = ^{load_addr[31:IDX_W+2], load_addr[1:0]};

  assign out_valid    = (count_q != '0);
  assign out_instr    = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign out_pc       = out_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign misalign_err = misalign_q;

  // Credit gate: queued plus in-flight words never exceed the FIFO depth.
  assign issue = !redirect_valid &&
                 ((32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH);
  assign push  = inflight_q && !redirect_valid;
  assign pop   = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = inflight_q;
    rd_instr_d   = rd_instr_q;
    rd_pc_d      = rd_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misalign_d   = misalign_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      inflight_d = issue;
      if (issue) begin
        rd_instr_d = mem_q[fetch_idx];
        rd_pc_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = rd_instr_q;
        fifo_pc_d[wr_ptr_q]    = rd_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      inflight_q   <= 1'b0;
      rd_instr_q   <= 32'h0;
      rd_pc_q      <= 32'h0;
      fifo_instr_q <= '{default: 32'h0};
      fifo_pc_q    <= '{default: 32'h0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      rd_instr_q   <= rd_instr_d;
      rd_pc_q      <= rd_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misalign_q   <= misalign_d;
    end
  end

  // Program contents survive reset; the fetch read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed scenarios plus a randomized run, all
// checked cycle by cycle against a queue-based model of the fetch stream.
module tb_fetch_prefetch_buffer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(
    .MEM_BYTES(256), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .misalign_err(misalign_err)
  );

  // Reference: 64-word memory, queue of words visible to decode, one pending read.
  logic [31:0] m_mem [64];
  logic [63:0] m_q [$];
  logic        m_inflight;
  logic [63:0] m_rd;
  logic [31:0] m_pc;
  logic        m_mis;

  function automatic void model_rst();
    m_q.delete();
    m_inflight = 1'b0;
    m_rd       = 64'h0;
    m_pc       = RESET_PC;
    m_mis      = 1'b0;
  endfunction

  function automatic logic [63:0] m_head();
    if (m_q.size() == 0) return 64'h0;
    return m_q[0];
  endfunction

  function automatic void model_edge();
    int occ;
    bit take;
    bit start;
    if (reset) begin
      model_rst();
    end else if (redirect_valid) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      occ   = m_q.size();
      start = (occ + int'(m_inflight)) < int'(FIFO_DEPTH);
      take  = (occ != 0) && out_ready;
      if (take) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_rd);
      m_inflight = start;
      if (start) begin
        m_rd = {m_pc, m_mem[m_pc[7:2]]};
        m_pc = m_pc + 32'd4;
      end
    end
    if (load_en) m_mem[load_addr[7:2]] = load_data;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1 model_rst();
    for (int i = 0; i < 64; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 0) ? 32'h00430820 : (i == 1) ? 32'h00A62022 : $urandom;
      cycle();
    end
    load_en = 1'b0;
    checks++;
    if ({out_valid, out_pc, out_instr, misalign_err} !== 66'h0)
      begin errors++; $display("FAIL reset_state got v=%0b pc=%h instr=%h mis=%0b want all 0", out_valid, out_pc, out_instr, misalign_err); end
    reset = 1'b0;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_edge1 got v=%0b want 0", out_valid); end
    cycle();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h00430820})
      begin errors++; $display("FAIL reset_edge2 got v=%0b pc=%h instr=%h want 1 0 00430820", out_valid, out_pc, out_instr); end
    cycle();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h4, 32'h00A62022})
      begin errors++; $display("FAIL reset_edge3 got v=%0b pc=%h instr=%h want 1 4 00A62022", out_valid, out_pc, out_instr); end
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(8 + 4 * k), m_mem[2 + k]})
        begin errors++; $display("FAIL reset_stream got v=%0b pc=%h instr=%h want pc=%h", out_valid, out_pc, out_instr, 32'(8 + 4 * k)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      checks++;
      if ({out_valid, out_pc, out_instr} !== {m_q.size() != 0, m_head()})
        begin errors++; $display("FAIL bp_stream got v=%0b pc=%h instr=%h want %h", out_valid, out_pc, out_instr, m_head()); end
    end
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0})
      begin errors++; $display("FAIL bp_head_hold got v=%0b pc=%h want 1 0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < 5; k++) begin
      if (out_valid) got.push_back(out_pc);
      cycle();
    end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL bp_count got %0d beats want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_order beat %0d got pc=%h want %h", i, got[i], 32'(i * 4)); end
    end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got v=%0b want 0", out_valid); end
    for (int k = 0; k < 5 && !seen; k++) begin
      cycle();
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if ({out_pc, out_instr} !== {32'h100, m_mem[0]})
          begin errors++; $display("FAIL redir_first got pc=%h instr=%h want 100 %h", out_pc, out_instr, m_mem[0]); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL redir_timeout got no valid want valid"); end
  endtask

  task automatic test_misalign();
    bit seen = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got %0b want 1", misalign_err); end
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (out_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if (out_pc !== 32'h100) begin errors++; $display("FAIL mis_resume got pc=%h want 100", out_pc); end
      end
    end
    checks++;
    if ({seen, misalign_err} !== 2'b11) begin errors++; $display("FAIL mis_sticky got seen=%0b mis=%0b want 1 1", seen, misalign_err); end
  endtask

  task automatic test_wrap_load();
    logic [63:0] beats [$];
    logic [31:0] old_w;
    logic [31:0] new_w;
    bit seen;
    redirect_valid = 1'b1; redirect_pc = 32'hF0; out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 20 && beats.size() < 6; k++) begin
      if (out_valid) beats.push_back({out_pc, out_instr});
      cycle();
    end
    checks++;
    if (beats.size() != 6) begin errors++; $display("FAIL wrap_count got %0d want 6", beats.size()); end
    else begin
      checks++;
      if (beats[3] !== {32'hFC, m_mem[63]}) begin errors++; $display("FAIL wrap_fc got %h want %h", beats[3], {32'hFC, m_mem[63]}); end
      checks++;
      if (beats[4] !== {32'h100, m_mem[0]}) begin errors++; $display("FAIL wrap_100 got %h want %h", beats[4], {32'h100, m_mem[0]}); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cycle();
    redirect_valid = 1'b0;
    old_w = m_mem[8];
    new_w = ~old_w;
    load_en = 1'b1; load_addr = 32'h23; load_data = new_w;
    cycle();
    load_en = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
        if (out_valid) begin
          seen = 1'b1;
          checks++;
          if ({out_pc, out_instr} !== {32'h20, (pass == 0) ? old_w : new_w})
            begin errors++; $display("FAIL load_pass%0d got pc=%h instr=%h want 20 %h", pass, out_pc, out_instr, (pass == 0) ? old_w : new_w); end
        end else cycle();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL load_timeout pass %0d got no valid want valid", pass); end
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      cycle();
      redirect_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && m_q.size() != 3; k++) cycle();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h40}) begin errors++; $display("FAIL mid_pre got v=%0b pc=%h want 1 40", out_valid, out_pc); end
    reset = 1'b1;
    #1 model_rst();
    checks++;
    if ({out_valid, out_pc, out_instr, misalign_err} !== 66'h0)
      begin errors++; $display("FAIL mid_async got v=%0b pc=%h instr=%h mis=%0b want all 0", out_valid, out_pc, out_instr, misalign_err); end
    cycle();
    reset = 1'b0; out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_edge1 got v=%0b want 0", out_valid); end
    cycle();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, RESET_PC, m_mem[RESET_PC[7:2]]})
      begin errors++; $display("FAIL mid_restart got v=%0b pc=%h instr=%h want 1 %h", out_valid, out_pc, out_instr, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    for (int k = 0; k < 400; k++) begin
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      rp = ($urandom % 8 == 0) ? 32'hFFFF_FFF4 : $urandom;
      if ($urandom % 4 != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      load_en     = ($urandom % 8) == 0;
      load_addr   = $urandom;
      load_data   = $urandom;
      cycle();
      checks++;
      if ({out_valid, out_pc, out_instr, misalign_err} !== {m_q.size() != 0, m_head(), m_mis})
        begin errors++; $display("FAIL rand_cycle%0d got v=%0b pc=%h instr=%h mis=%0b want %0b %h %0b", k, out_valid, out_pc, out_instr, misalign_err, m_q.size() != 0, m_head(), m_mis); end
    end
    redirect_valid = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_wrap_load();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
